// File: rtl/logic_unit_pipe_pkg.sv
// Shared types and the bitwise operation table for the pipelined logic unit.
// logic_op works on a wide vector; callers truncate to their own WIDTH.
package logic_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int OPCODE_W  = 3;
  localparam int MAX_W     = 64;

  typedef enum logic [OPCODE_W-1:0] {
    OP_OR   = 3'b000,
    OP_AND  = 3'b001,
    OP_NAND = 3'b010,
    OP_NOR  = 3'b011,
    OP_XOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_NOT  = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  // Purely per-bit, so zero-extended upper bits never affect the truncated result.
  function automatic logic [MAX_W-1:0] logic_op(input op_e op,
                                                input logic [MAX_W-1:0] a,
                                                input logic [MAX_W-1:0] b);
    logic [MAX_W-1:0] r;
    r = a;
    unique case (op)
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      OP_NOT:  r = ~a;
      OP_PASS: r = a;
      default: r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bundle of the pipelined logic unit.
interface logic_unit_pipe_if
  import logic_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int OP_W  = OPCODE_W
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [OP_W-1:0]  opcode;
  logic             acc_sel;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_logic;
  logic             flag_zero;
  logic             flag_ones;
  logic             flag_par;

  modport master (
    output in_valid, in1, in2, opcode, acc_sel, acc_clr, out_ready,
    input  in_ready, out_valid, out_logic, flag_zero, flag_ones, flag_par
  );

  modport slave (
    input  in_valid, in1, in2, opcode, acc_sel, acc_clr, out_ready,
    output in_ready, out_valid, out_logic, flag_zero, flag_ones, flag_par
  );
endinterface

// File: rtl/logic_unit_pipe_core.sv
// Combinational bitwise operation plus zero/all-ones/parity status.
module logic_core
  import logic_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ones,
  output logic             par
);

  assign result = WIDTH'(logic_op(op, MAX_W'(a), MAX_W'(b)));
  assign zero   = (result == '0);
  assign ones   = &result;
  assign par    = ^result;

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined logic unit with valid/ready handshake and a chaining accumulator.
// S1 captures the beat; S2 holds the registered result, flags and updates acc.
module logic_unit_pipe
  import logic_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int OP_W  = OPCODE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  logic_unit_pipe_if.slave  bus
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_in1;
  logic [WIDTH-1:0] s1_in2;
  logic [OP_W-1:0]  s1_op;
  logic             s1_acc_sel;
  logic             s1_acc_clr;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_result;
  logic             s2_zero;
  logic             s2_ones;
  logic             s2_par;

  logic [WIDTH-1:0] acc;

  logic             s2_ready;
  logic             s2_load;
  logic             in_fire;

  logic [WIDTH-1:0] core_a;
  logic [WIDTH-1:0] core_result;
  logic             core_zero;
  logic             core_ones;
  logic             core_par;

  assign s2_ready     = !s2_valid || bus.out_ready;
  assign s2_load      = s1_valid && s2_ready;
  assign bus.in_ready = !s1_valid || s2_ready;
  assign in_fire      = bus.in_valid && bus.in_ready;

  // Clear wins over select so a chain can be restarted without a dummy beat.
  assign core_a = s1_acc_clr ? '0 : (s1_acc_sel ? acc : s1_in1);

  logic_core #(.WIDTH(WIDTH)) u_core (
    .op     (op_e'(s1_op)),
    .a      (core_a),
    .b      (s1_in2),
    .result (core_result),
    .zero   (core_zero),
    .ones   (core_ones),
    .par    (core_par)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_in1     <= '0;
      s1_in2     <= '0;
      s1_op      <= '0;
      s1_acc_sel <= 1'b0;
      s1_acc_clr <= 1'b0;
    end else if (in_fire) begin
      s1_valid   <= 1'b1;
      s1_in1     <= bus.in1;
      s1_in2     <= bus.in2;
      s1_op      <= bus.opcode;
      s1_acc_sel <= bus.acc_sel;
      s1_acc_clr <= bus.acc_clr;
    end else if (s2_load) begin
      s1_valid   <= 1'b0;
    end
  end

  // acc is written on the S2 load edge so the next beat in S1 already sees it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_zero   <= 1'b0;
      s2_ones   <= 1'b0;
      s2_par    <= 1'b0;
      acc       <= '0;
    end else if (s2_load) begin
      s2_valid  <= 1'b1;
      s2_result <= core_result;
      s2_zero   <= core_zero;
      s2_ones   <= core_ones;
      s2_par    <= core_par;
      acc       <= core_result;
    end else if (bus.out_ready) begin
      s2_valid  <= 1'b0;
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.out_logic = s2_result;
  assign bus.flag_zero = s2_zero;
  assign bus.flag_ones = s2_ones;
  assign bus.flag_par  = s2_par;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: directed vector table, backpressure/reset sequences,
// randomized traffic against an in-order queue model, and a WIDTH=16 spot check.
module tb_logic_unit_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic_unit_pipe_if #(.WIDTH(8),  .OP_W(3)) b8 ();
  logic_unit_pipe_if #(.WIDTH(16), .OP_W(3)) b16 ();

  logic_unit_pipe #(.WIDTH(8),  .OP_W(3)) dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
  logic_unit_pipe #(.WIDTH(16), .OP_W(3)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int popped = 0;

  typedef struct {
    logic [7:0] res;
    logic       z, o, p;
    int         acc_cyc;
  } exp_t;

  typedef struct {
    logic [7:0] a, b;
    logic [2:0] op;
    logic       sel, clr;
    logic [7:0] res;
    logic       z, o, p;
  } vec_t;

  exp_t       q[$];
  vec_t       tbl[12];
  logic [7:0] m_acc;
  bit         chk_lat;
  bit         use_tbl;
  exp_t       tbl_exp;
  bit         prev_stall;
  logic [10:0] prev_snap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    case (op)
      3'd0:    return a | b;
      3'd1:    return a & b;
      3'd2:    return ~(a & b);
      3'd3:    return ~(a | b);
      3'd4:    return a ^ b;
      3'd5:    return ~(a ^ b);
      3'd6:    return ~a;
      default: return a;
    endcase
  endfunction

  // One cycle: called at a negedge, drives inputs, scores, returns at the next negedge.
  task automatic step(input bit v, input logic [7:0] a, input logic [7:0] bb,
                      input logic [2:0] op, input bit sel, input bit clr,
                      input bit ordy, output bit accepted);
    exp_t e;
    logic [7:0] av;
    b8.in_valid  = v;
    b8.in1       = a;
    b8.in2       = bb;
    b8.opcode    = op;
    b8.acc_sel   = sel;
    b8.acc_clr   = clr;
    b8.out_ready = ordy;
    #1;
    if (prev_stall)
      chk("hold_out", {21'd0, b8.out_valid, b8.out_logic, b8.flag_zero, b8.flag_ones},
          {21'd0, prev_snap});
    prev_stall = b8.out_valid && !ordy;
    prev_snap  = {b8.out_valid, b8.out_logic, b8.flag_zero, b8.flag_ones};
    accepted = v && b8.in_ready;
    if (b8.out_valid && ordy) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_out: got %0h expected no result", b8.out_logic);
      end else begin
        e = q.pop_front();
        popped++;
        chk("out_logic", {24'd0, b8.out_logic}, {24'd0, e.res});
        chk("flags", {29'd0, b8.flag_zero, b8.flag_ones, b8.flag_par},
            {29'd0, e.z, e.o, e.p});
        if (chk_lat) chk("latency", cyc - e.acc_cyc, 2);
      end
    end
    if (accepted) begin
      av    = clr ? 8'h00 : (sel ? m_acc : a);
      m_acc = ref_op(op, av, bb);
      if (use_tbl) e = tbl_exp;
      else begin
        e.res = m_acc;
        e.z   = (m_acc == 8'h00);
        e.o   = (m_acc == 8'hFF);
        e.p   = ^m_acc;
      end
      e.acc_cyc = cyc;
      q.push_back(e);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    bit acc;
    int n = 0;
    while (q.size() != 0 && n < 30) begin
      step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1, acc);
      n++;
    end
    chk("drain_empty", q.size(), 0);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1, acc);
    chk("idle_out_valid", {31'd0, b8.out_valid}, 0);
  endtask

  task automatic push_beat(input logic [7:0] a, input logic [7:0] bb, input logic [2:0] op,
                           input bit sel, input bit clr, input bit ordy);
    bit acc;
    int tries = 0;
    do begin
      step(1'b1, a, bb, op, sel, clr, ordy, acc);
      tries++;
    end while (!acc && tries < 20);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected acceptance within 20 cycles");
    end
  endtask

  initial begin
    bit acc;
    int base;
    bit seen;

    tbl[0]  = '{8'h3C, 8'h0F, 3'd0, 1'b0, 1'b0, 8'h3F, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{8'h3C, 8'h0F, 3'd1, 1'b0, 1'b0, 8'h0C, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{8'h3C, 8'h0F, 3'd4, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{8'h3C, 8'h0F, 3'd3, 1'b0, 1'b0, 8'hC0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{8'h3C, 8'h0F, 3'd5, 1'b0, 1'b0, 8'hCC, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{8'hAA, 8'h55, 3'd1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{8'hAA, 8'h55, 3'd2, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{8'h5A, 8'hFF, 3'd6, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{8'h5A, 8'hFF, 3'd7, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{8'h00, 8'h01, 3'd4, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{8'h77, 8'h02, 3'd4, 1'b1, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{8'h77, 8'h04, 3'd0, 1'b1, 1'b0, 8'h07, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0;
    {b8.in_valid, b8.in1, b8.in2, b8.opcode, b8.acc_sel, b8.acc_clr, b8.out_ready} = '0;
    {b16.in_valid, b16.in1, b16.in2, b16.opcode, b16.acc_sel, b16.acc_clr, b16.out_ready} = '0;
    m_acc = 8'h00;
    prev_stall = 1'b0;
    prev_snap = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, b8.in_ready}, 1);
    chk("rst_out_valid", {31'd0, b8.out_valid}, 0);
    chk("rst_out_logic", {24'd0, b8.out_logic}, 0);
    chk("rst_flags", {29'd0, b8.flag_zero, b8.flag_ones, b8.flag_par}, 0);
    @(negedge clk);

    // Directed table, out_ready held high: exact 2-cycle latency, no bubbles.
    chk_lat = 1'b1;
    use_tbl = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tbl_exp.res = tbl[i].res;
      tbl_exp.z   = tbl[i].z;
      tbl_exp.o   = tbl[i].o;
      tbl_exp.p   = tbl[i].p;
      push_beat(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].sel, tbl[i].clr, 1'b1);
    end
    drain();
    chk_lat = 1'b0;
    use_tbl = 1'b0;

    // Backpressure: three beats against a stalled output for four cycles.
    base = popped;
    step(1'b1, 8'h11, 8'h22, 3'd0, 1'b0, 1'b0, 1'b0, acc);
    chk("bp_accept_a", {31'd0, acc}, 1);
    step(1'b1, 8'hF0, 8'h0F, 3'd1, 1'b0, 1'b0, 1'b0, acc);
    chk("bp_accept_b", {31'd0, acc}, 1);
    chk("bp_in_ready_full", {31'd0, b8.in_ready}, 0);
    chk("bp_out_first", {23'd0, b8.out_valid, b8.out_logic}, {23'd0, 1'b1, 8'h33});
    step(1'b1, 8'h5A, 8'h00, 3'd6, 1'b0, 1'b0, 1'b0, acc);
    chk("bp_reject_c0", {31'd0, acc}, 0);
    step(1'b1, 8'h5A, 8'h00, 3'd6, 1'b0, 1'b0, 1'b0, acc);
    chk("bp_reject_c1", {31'd0, acc}, 0);
    chk("bp_out_held", {23'd0, b8.out_valid, b8.out_logic}, {23'd0, 1'b1, 8'h33});
    push_beat(8'h5A, 8'h00, 3'd6, 1'b0, 1'b0, 1'b1);
    drain();
    chk("bp_count", popped - base, 3);

    // Reset between edges with two beats in flight.
    step(1'b1, 8'h0F, 8'hF0, 3'd0, 1'b0, 1'b1, 1'b1, acc);
    step(1'b1, 8'h01, 8'h80, 3'd0, 1'b1, 1'b0, 1'b1, acc);
    b8.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, b8.out_valid}, 0);
    chk("midrst_in_ready", {31'd0, b8.in_ready}, 1);
    chk("midrst_out_logic", {24'd0, b8.out_logic}, 0);
    q.delete();
    m_acc = 8'h00;
    prev_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    use_tbl = 1'b1;
    tbl_exp.res = 8'h10;
    tbl_exp.z = 1'b0;
    tbl_exp.o = 1'b0;
    tbl_exp.p = 1'b1;
    push_beat(8'hEE, 8'h10, 3'd0, 1'b1, 1'b0, 1'b1);
    use_tbl = 1'b0;
    drain();

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) != 0, acc);
    end
    drain();

    // WIDTH=16 instance: NOT ignores B and inverts all 16 bits.
    b16.in_valid  = 1'b1;
    b16.in1       = 16'h00FF;
    b16.in2       = 16'h1234;
    b16.opcode    = 3'd6;
    b16.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b16.in_valid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 6 && !seen; n++) begin
      if (b16.out_valid) begin
        seen = 1'b1;
        chk("w16_not", {16'd0, b16.out_logic}, 32'h0000FF00);
        chk("w16_flags", {29'd0, b16.flag_zero, b16.flag_ones, b16.flag_par}, 0);
      end else @(negedge clk);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL w16_timeout: got out_valid=0 expected a result within 6 cycles");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
